// File: rtl/fourier_synth.sv
// Time-multiplexed Fourier-series synthesiser.
// One phase accumulator feeds N_HARM harmonic slots through a shared sine ROM
// and one multiply-accumulate step per clock. Each sample costs N_HARM+1 clocks.
//
// state | meaning
// IDLE  | waiting for enable; out holds the last sample
// MAC   | one harmonic term accumulated per clock, slot k = 0..N_HARM-1
// DONE  | publish acc, advance phase, restart or fall back to IDLE
module fourier_synth #(
  parameter int N_HARM  = 4,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = 16,
  localparam int OUT_W  = DATA_W + $clog2(N_HARM) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PHASE_W-1:0]      fcw,
  input  logic [1:0]              mode,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int LUT_N  = 2 ** LUT_AW;
  localparam int KW     = (N_HARM > 1) ? $clog2(N_HARM) : 1;
  localparam int H_MAX  = 2 * N_HARM - 1;
  localparam int HW     = $clog2(H_MAX + 1);
  localparam int GAIN_W = 17;
  localparam int PW     = DATA_W + GAIN_W + 1;

  // Full-wave sine table, round-to-nearest of the scaled sine.
  function automatic logic [LUT_N*DATA_W-1:0] build_rom();
    logic [LUT_N*DATA_W-1:0] t;
    real amp;
    real x;
    int  v;
    t   = '0;
    amp = real'((1 << (DATA_W - 1)) - 1);
    for (int i = 0; i < LUT_N; i++) begin
      x = amp * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(LUT_N));
      v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      t[i*DATA_W +: DATA_W] = DATA_W'(v);
    end
    return t;
  endfunction

  // Harmonic gain round(2^16/h); no exact half can occur for h <= 31.
  function automatic logic [(H_MAX+1)*GAIN_W-1:0] build_gain();
    logic [(H_MAX+1)*GAIN_W-1:0] t;
    int g;
    t = '0;
    for (int h = 1; h <= H_MAX; h++) begin
      g = (131072 + h) / (2 * h);
      t[h*GAIN_W +: GAIN_W] = GAIN_W'(g);
    end
    return t;
  endfunction

  localparam logic [LUT_N*DATA_W-1:0]      ROM  = build_rom();
  localparam logic [(H_MAX+1)*GAIN_W-1:0]  GAIN = build_gain();

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state, state_nx;
  logic [PHASE_W-1:0]        phase, hphase, fcw_l, step;
  logic [1:0]                mode_l;
  logic [KW-1:0]             k;
  logic signed [OUT_W-1:0]   acc;
  logic                      last_slot, start, mac_en, done;
  logic [LUT_AW-1:0]         rom_addr;
  logic signed [DATA_W-1:0]  rom_q;
  logic [HW-1:0]             h;
  logic [GAIN_W-1:0]         gain;
  logic                      neg, zero;
  logic signed [PW-1:0]      prod;
  logic signed [OUT_W-1:0]   term;

  assign last_slot = (k == KW'(N_HARM - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = MAC;
      MAC:     if (last_slot) state_nx = DONE;
      DONE:    state_nx = enable ? MAC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    busy   = (state != IDLE);
    mac_en = (state == MAC);
    done   = (state == DONE);
    start  = enable && ((state == IDLE) || (state == DONE));
  end

  // Harmonic number, sign and muting for the current slot.
  always_comb begin
    h    = HW'(1);
    neg  = 1'b0;
    zero = 1'b0;
    case (mode_l)
      2'd0: h = HW'(2 * int'(k) + 1);
      2'd1: begin
        h   = HW'(int'(k) + 1);
        neg = k[0];
      end
      default: zero = (k != '0);
    endcase
  end

  // Term = (rom * gain) >>> 16, negated after the shift, muted in SINGLE slots > 0.
  always_comb begin
    rom_addr = hphase[PHASE_W-1 -: LUT_AW];
    rom_q    = ROM[int'(rom_addr)*DATA_W +: DATA_W];
    gain     = GAIN[int'(h)*GAIN_W +: GAIN_W];
    prod     = PW'(rom_q) * PW'($signed({1'b0, gain}));
    term     = OUT_W'(prod >>> 16);
    if (neg)  term = -term;
    if (zero) term = '0;
    step     = (mode_l == 2'd0) ? {phase[PHASE_W-2:0], 1'b0} : phase;
  end

  // Datapath: accumulate, publish, advance phase and relatch controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      hphase    <= '0;
      fcw_l     <= '0;
      mode_l    <= '0;
      k         <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mac_en) begin
        acc    <= acc + term;
        hphase <= hphase + step;
        k      <= k + KW'(1);
      end
      if (done) begin
        out       <= acc;
        out_valid <= 1'b1;
        phase     <= phase + fcw_l;
      end
      if (start) begin
        fcw_l  <= fcw;
        mode_l <= mode;
        acc    <= '0;
        k      <= '0;
        hphase <= done ? (phase + fcw_l) : phase;
      end
    end
  end

endmodule

// File: tb/tb_fourier_synth.sv
// Bench for fourier_synth: a per-edge transaction model (sample countdown plus
// closed-form Fourier sum) checked every cycle, followed by known sequences.
module tb_fourier_synth;

  localparam int N_HARM  = 4;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int DATA_W  = 16;
  localparam int OUT_W   = DATA_W + $clog2(N_HARM) + 1;
  localparam longint PMOD = longint'(1) << PHASE_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable = 1'b0;
  logic [PHASE_W-1:0]      fcw = '0;
  logic [1:0]              mode = '0;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;
  logic                    busy;

  int n_cmp = 0;
  int n_bad = 0;
  longint obs_q[$];

  fourier_synth #(
    .N_HARM(N_HARM), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fcw(fcw), .mode(mode),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint rom_val(input longint addr);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(addr) / 256.0);
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
  endfunction

  // Closed form: slot k uses harmonic h at phase h*phase.
  function automatic longint model_sample(input longint ph, input int md);
    longint sum, hp, g, t;
    int h, sgn, nslot;
    sum = 0;
    nslot = (md >= 2) ? 1 : N_HARM;
    for (int k = 0; k < nslot; k++) begin
      h   = (md == 0) ? 2 * k + 1 : k + 1;
      sgn = (md == 1 && (k % 2) == 1) ? -1 : 1;
      hp  = (longint'(h) * ph) % PMOD;
      g   = longint'($rtoi(65536.0 / real'(h) + 0.5));
      t   = (rom_val(hp >> (PHASE_W - LUT_AW)) * g) >>> 16;
      sum += sgn * t;
    end
    return sum;
  endfunction

  bit     m_run = 0;
  int     m_cnt = 0;
  longint m_phase = 0, m_fcw = 0, m_out = 0;
  int     m_mode = 0;
  bit     m_valid = 0;
  bit     s_rst, s_en;
  longint s_fcw;
  int     s_mode;

  // Reference model advanced on each edge, outputs compared 1 ns later.
  always @(posedge clk) begin
    s_rst = rst; s_en = enable; s_fcw = longint'(fcw); s_mode = int'(mode);
    m_valid = 0;
    if (s_rst) begin
      m_run = 0; m_phase = 0; m_out = 0;
    end else if (m_run) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_out = model_sample(m_phase, m_mode);
        m_valid = 1;
        m_phase = (m_phase + m_fcw) % PMOD;
        if (s_en) begin
          m_fcw = s_fcw; m_mode = s_mode; m_cnt = N_HARM + 1;
        end else m_run = 0;
      end
    end else if (s_en) begin
      m_run = 1; m_cnt = N_HARM + 1; m_fcw = s_fcw; m_mode = s_mode;
    end
    #1;
    chk("out_valid", longint'(out_valid), longint'(m_valid));
    chk("busy", longint'(busy), longint'(m_run));
    chk("out", longint'($signed(out)), m_out);
    if (out_valid) obs_q.push_back(longint'($signed(out)));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick(3);
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic collect(input string tag, input int n);
    int budget;
    budget = n * (N_HARM + 1) * 2 + 10;
    while (obs_q.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
    if (obs_q.size() < n) chk({tag, "_timeout"}, obs_q.size(), n);
  endtask

  function automatic longint obs_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : 64'sd999999;
  endfunction

  initial begin
    tick(3);
    chk("reset_out", longint'($signed(out)), 0);
    chk("reset_busy", longint'(busy), 0);
    rst = 1'b0;

    // Pure sine, quarter-turn steps.
    do_reset();
    mode = 2'd2; fcw = 24'h400000; enable = 1'b1;
    collect("single", 5);
    chk("single_s0", obs_at(0), 0);
    chk("single_s1", obs_at(1), 32767);
    chk("single_s2", obs_at(2), 0);
    chk("single_s3", obs_at(3), -32767);
    chk("single_s4", obs_at(4), 0);

    // Reset in the middle of a MAC run.
    do_reset();
    mode = 2'd2; fcw = 24'h400000; enable = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(3);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_valid", longint'(out_valid), 0);
    rst = 1'b0;
    obs_q.delete();
    collect("midrst", 2);
    chk("midrst_s0", obs_at(0), 0);
    chk("midrst_s1", obs_at(1), 32767);

    // Square and sawtooth at quarter-turn steps.
    do_reset();
    mode = 2'd0; fcw = 24'h400000; enable = 1'b1;
    collect("square", 2);
    chk("square_s0", obs_at(0), 0);
    chk("square_s1", obs_at(1), 23716);

    do_reset();
    mode = 2'd1; fcw = 24'h400000; enable = 1'b1;
    collect("saw", 2);
    chk("saw_s0", obs_at(0), 0);
    chk("saw_s1", obs_at(1), 21844);

    // Negative step wraps through zero.
    do_reset();
    mode = 2'd2; fcw = 24'hC00000; enable = 1'b1;
    collect("wrap", 4);
    chk("wrap_s0", obs_at(0), 0);
    chk("wrap_s1", obs_at(1), -32767);
    chk("wrap_s2", obs_at(2), 0);
    chk("wrap_s3", obs_at(3), 32767);

    // Drop enable and change controls during sample 2, then resume.
    do_reset();
    mode = 2'd2; fcw = 24'h200000; enable = 1'b1;
    collect("ctrl", 2);
    enable = 1'b0; fcw = 24'h800000; mode = 2'd0;
    tick(N_HARM + 3);
    chk("ctrl_count", obs_q.size(), 3);
    chk("ctrl_s1", obs_at(1), 23170);
    chk("ctrl_s2", obs_at(2), 32767);
    chk("ctrl_idle", longint'(busy), 0);
    enable = 1'b1;
    collect("resume", 4);
    chk("resume_s3", obs_at(3), 22949);

    // Randomised traffic checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) fcw = PHASE_W'($urandom);
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      rst = ($urandom_range(199) == 0);
      tick(1);
    end
    rst = 1'b0;
    enable = 1'b0;
    tick(2 * (N_HARM + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
